// File: rtl/ram_2w1r_wr_arb_if.sv
// Write-side bus between NREQ requesters, the arbiter and the two RAM write ports.
// The master modport is the requester/RAM side; the slave modport is the arbiter.
interface ram_2w1r_wr_arb_if #(
    parameter int WIDTH  = 8,
    parameter int DEEPTH = 8,
    parameter int NREQ   = 4
);
    logic                     stall;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ*DEEPTH-1:0]   req_addr;
    logic [NREQ*WIDTH-1:0]    req_data;
    logic [NREQ-1:0]          req_ready;

    logic [DEEPTH-1:0]        write_addr_A;
    logic [WIDTH-1:0]         write_data_A;
    logic                     write_EN_A;
    logic [DEEPTH-1:0]        write_addr_B;
    logic [WIDTH-1:0]         write_data_B;
    logic                     write_EN_B;

    modport master (
        output stall, req_valid, req_addr, req_data,
        input  req_ready,
        input  write_addr_A, write_data_A, write_EN_A,
        input  write_addr_B, write_data_B, write_EN_B
    );

    modport slave (
        input  stall, req_valid, req_addr, req_data,
        output req_ready,
        output write_addr_A, write_data_A, write_EN_A,
        output write_addr_B, write_data_B, write_EN_B
    );
endinterface

// File: rtl/ram_2w1r_wr_arb.sv
// Rotating-priority arbiter sharing the two RAM write ports among NREQ requesters.
// Port B never carries port A's address in the same cycle, so no write is lost.
module ram_2w1r_wr_arb #(
    parameter int WIDTH  = 8,
    parameter int DEEPTH = 8,
    parameter int NREQ   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_2w1r_wr_arb_if.slave      bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0]      r_ptr;
    logic               r_en_a;
    logic [DEEPTH-1:0]  r_addr_a;
    logic [WIDTH-1:0]   r_data_a;
    logic               r_en_b;
    logic [DEEPTH-1:0]  r_addr_b;
    logic [WIDTH-1:0]   r_data_b;

    logic [DEEPTH-1:0]  w_addr [NREQ];
    logic [WIDTH-1:0]   w_data [NREQ];

    logic               w_a_hit;
    logic [IW-1:0]      w_a_idx;
    logic               w_b_hit;
    logic [IW-1:0]      w_b_idx;
    logic [IW:0]        w_sum;
    logic [IW-1:0]      w_idx;
    logic               w_a_gnt;
    logic               w_b_gnt;
    logic [NREQ-1:0]    w_ready;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_addr[g] = bus.req_addr[g*DEEPTH +: DEEPTH];
        assign w_data[g] = bus.req_data[g*WIDTH +: WIDTH];
    end

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
        if (idx == IW'(NREQ - 1))
            return '0;
        return idx + 1'b1;
    endfunction

    // Circular scan from r_ptr: first valid wins A, then the first later valid
    // requester with a different address wins B; the scan stops short of r_ptr.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
        w_a_hit = 1'b0;
        w_a_idx = '0;
        w_b_hit = 1'b0;
        w_b_idx = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(NREQ))
                w_sum = w_sum - (IW+1)'(NREQ);
            w_idx = w_sum[IW-1:0];
            if (!w_a_hit && bus.req_valid[w_idx]) begin
                w_a_hit = 1'b1;
                w_a_idx = w_idx;
            end else if (w_a_hit && !w_b_hit && bus.req_valid[w_idx]
                         && (w_addr[w_idx] != w_addr[w_a_idx])) begin
                w_b_hit = 1'b1;
                w_b_idx = w_idx;
            end
        end
    end

    assign w_a_gnt = w_a_hit && !bus.stall && !rst;
    assign w_b_gnt = w_b_hit && !bus.stall && !rst;

    always_comb begin
        w_ready = '0;
        if (w_a_gnt)
            w_ready[w_a_idx] = 1'b1;
        if (w_b_gnt)
            w_ready[w_b_idx] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            r_en_a   <= 1'b0;
            r_addr_a <= '0;
            r_data_a <= '0;
            r_en_b   <= 1'b0;
            r_addr_b <= '0;
            r_data_b <= '0;
        end else begin
            r_en_a <= w_a_gnt;
            r_en_b <= w_b_gnt;
            if (w_a_gnt) begin
                r_addr_a <= w_addr[w_a_idx];
                r_data_a <= w_data[w_a_idx];
            end
            if (w_b_gnt) begin
                r_addr_b <= w_addr[w_b_idx];
                r_data_b <= w_data[w_b_idx];
            end
            if (w_b_gnt)
                r_ptr <= wrap_inc(w_b_idx);
            else if (w_a_gnt)
                r_ptr <= wrap_inc(w_a_idx);
        end
    end

    assign bus.req_ready    = w_ready;
    assign bus.write_EN_A   = r_en_a;
    assign bus.write_addr_A = r_addr_a;
    assign bus.write_data_A = r_data_a;
    assign bus.write_EN_B   = r_en_b;
    assign bus.write_addr_B = r_addr_b;
    assign bus.write_data_B = r_data_b;
endmodule
